// File: rtl/com_tr_pkg.sv
// Shared types and helpers for the single-event-transient monitor.
package com_tr_pkg;

    // Per-channel mismatch-run classifier states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PERM = 2'd2
    } tr_state_e;

    // Width of the run-length counter: it must hold values up to perm_cyc.
    function automatic int run_width(input int perm_cyc);
        return $clog2(perm_cyc + 1);
    endfunction

endpackage

// File: rtl/com_tr_ch.sv
// One monitored channel: compares the two registered copies, classifies each
// mismatch run as transient or permanent, and keeps the saturating transient
// counter and the sticky permanent flag.
module com_tr_ch
    import com_tr_pkg::*;
#(
    parameter int IN_WIDTH = 8,
    parameter int CNT_W    = 8,
    parameter int PERM_CYC = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [IN_WIDTH-1:0] a,
    input  logic [IN_WIDTH-1:0] b,
    input  logic                clear,
    output logic                error,
    output logic [CNT_W-1:0]    cnt,
    output logic                perm
);

    localparam int               RUN_W   = run_width(PERM_CYC);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(PERM_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    tr_state_e        state;
    tr_state_e        state_nxt;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             perm_nxt;
    logic             mism;

    // A disabled channel never reports a mismatch.
    assign mism = en & (|(a ^ b));

    // State register plus the registered mismatch flag, counter and sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            run   <= '0;
            cnt   <= '0;
            perm  <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= state_nxt;
            run   <= run_nxt;
            cnt   <= cnt_nxt;
            perm  <= perm_nxt;
            error <= mism;
        end
    end

    // Next-state logic. Clear wins over everything; a disable mid-run aborts
    // the run without counting it, since a missing mismatch then says nothing.
    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        cnt_nxt   = cnt;
        perm_nxt  = perm;
        if (clear) begin
            state_nxt = IDLE;
            run_nxt   = '0;
            cnt_nxt   = '0;
            perm_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mism) begin
                        state_nxt = RUN;
                        run_nxt   = RUN_W'(1);
                    end
                end
                RUN: begin
                    if (!en) begin
                        state_nxt = IDLE;
                        run_nxt   = '0;
                    end else if (mism) begin
                        run_nxt = run + RUN_W'(1);
                        if (run_nxt == RUN_MAX) begin
                            state_nxt = PERM;
                            perm_nxt  = 1'b1;
                        end
                    end else begin
                        if (cnt != CNT_MAX) begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                        state_nxt = IDLE;
                        run_nxt   = '0;
                    end
                end
                PERM: begin
                    perm_nxt = 1'b1;
                end
                default: begin
                    state_nxt = IDLE;
                    run_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/com_tr_mc.sv
// Multi-channel transient monitor top: registers both copies and the enables,
// runs one classifier per channel and folds the results into one interrupt.
module com_tr_mc
    import com_tr_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int IN_WIDTH = 8,
    parameter int CNT_W    = 8,
    parameter int PERM_CYC = 4
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [N_CH-1:0]          en_i,
    input  logic [N_CH*IN_WIDTH-1:0] sig_a_i,
    input  logic [N_CH*IN_WIDTH-1:0] sig_b_i,
    input  logic [N_CH-1:0]          clear_i,
    input  logic [CNT_W-1:0]         thresh_i,
    output logic [N_CH-1:0]          error_o,
    output logic [N_CH*CNT_W-1:0]    trans_cnt_o,
    output logic [N_CH-1:0]          perm_o,
    output logic                     irq_o
);

    logic [N_CH*IN_WIDTH-1:0] a_q;
    logic [N_CH*IN_WIDTH-1:0] b_q;
    logic [N_CH-1:0]          en_q;
    logic [CNT_W-1:0]         cnt_arr [N_CH];
    logic                     irq_nxt;

    // Input sampling stage; the enable travels with the data it qualifies.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            a_q  <= '0;
            b_q  <= '0;
            en_q <= '0;
        end else begin
            a_q  <= sig_a_i;
            b_q  <= sig_b_i;
            en_q <= en_i;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        com_tr_ch #(
            .IN_WIDTH (IN_WIDTH),
            .CNT_W    (CNT_W),
            .PERM_CYC (PERM_CYC)
        ) u_ch (
            .clk   (clk_i),
            .rst_n (rstn_i),
            .en    (en_q[c]),
            .a     (a_q[c*IN_WIDTH +: IN_WIDTH]),
            .b     (b_q[c*IN_WIDTH +: IN_WIDTH]),
            .clear (clear_i[c]),
            .error (error_o[c]),
            .cnt   (cnt_arr[c]),
            .perm  (perm_o[c])
        );
        assign trans_cnt_o[c*CNT_W +: CNT_W] = cnt_arr[c];
    end

    // Interrupt request: any permanent fault, or any counter at/above a nonzero threshold.
    always_comb begin
        irq_nxt = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (perm_o[c] || ((thresh_i != '0) && (cnt_arr[c] >= thresh_i))) begin
                irq_nxt = 1'b1;
            end
        end
    end

    // Registered interrupt toward the safety unit.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= irq_nxt;
        end
    end

endmodule

// File: tb/tb_com_tr_mc.sv
// Directed bench for com_tr_mc with 4 channels, 8-bit copies, 4-bit counters.
module tb_com_tr_mc;

    localparam int NCH = 4;
    localparam int INW = 8;
    localparam int CW  = 4;
    localparam int PC  = 4;

    logic                clk = 1'b0;
    logic                rstN;
    logic [NCH-1:0]      en;
    logic [NCH*INW-1:0]  sigA;
    logic [NCH*INW-1:0]  sigB;
    logic [NCH-1:0]      clear;
    logic [CW-1:0]       thresh;
    logic [NCH-1:0]      error;
    logic [NCH*CW-1:0]   transCnt;
    logic [NCH-1:0]      perm;
    logic                irq;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] base;

    com_tr_mc #(
        .N_CH     (NCH),
        .IN_WIDTH (INW),
        .CNT_W    (CW),
        .PERM_CYC (PC)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstN),
        .en_i        (en),
        .sig_a_i     (sigA),
        .sig_b_i     (sigB),
        .clear_i     (clear),
        .thresh_i    (thresh),
        .error_o     (error),
        .trans_cnt_o (transCnt),
        .perm_o      (perm),
        .irq_o       (irq)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Copy A is the base value; copy B is the base with the given bits flipped.
    task automatic applyStimulus(input logic [31:0] flip);
        sigA = base;
        sigB = base ^ flip;
    endtask

    // Advance n clock edges and land 1 ns after the last one.
    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] bitOf(input int c, input int b);
        return 32'h1 << (c * INW + b);
    endfunction

    function automatic logic [CW-1:0] cntOf(input int c);
        return transCnt[c*CW +: CW];
    endfunction

    logic [31:0] acc;
    int          model;
    logic        irqExp;

    // Directed sequence: reset, idle, transients, permanent, saturation,
    // clear priority, enable abort, async reset.
    initial begin
        base   = $urandom;
        rstN   = 1'b0;
        en     = 4'hF;
        clear  = 4'h0;
        thresh = 4'd0;
        sigA   = '0;
        sigB   = '0;
        waitCycles(3);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_perm", perm, 0);
        checkOutput("rst_cnt", transCnt, 0);
        checkOutput("rst_irq", irq, 0);
        rstN = 1'b1;

        acc = '0;
        for (int i = 0; i < 100; i++) begin
            base = $urandom;
            applyStimulus(32'h0);
            waitCycles(1);
            acc = acc | {7'b0, irq, perm, error, transCnt};
        end
        checkOutput("idle_quiet", acc, 0);
        base = $urandom;
        applyStimulus(32'h0);
        waitCycles(3);

        applyStimulus(bitOf(1, 3));
        waitCycles(1);
        checkOutput("t1_latency", error, 0);
        applyStimulus(32'h0);
        waitCycles(1);
        checkOutput("t1_error", error, 4'b0010);
        checkOutput("t1_cnt_hold", transCnt, 0);
        waitCycles(1);
        checkOutput("t1_fall", error, 0);
        checkOutput("t1_cnt", transCnt, 16'h0010);

        applyStimulus(bitOf(1, 3));
        waitCycles(3);
        applyStimulus(32'h0);
        waitCycles(1);
        checkOutput("t3_error", error, 4'b0010);
        checkOutput("t3_perm_low", perm, 0);
        waitCycles(1);
        checkOutput("t3_fall", error, 0);
        checkOutput("t3_cnt", transCnt, 16'h0020);
        checkOutput("t3_perm", perm, 0);
        checkOutput("t3_irq", irq, 0);

        applyStimulus(bitOf(0, 0));
        waitCycles(4);
        checkOutput("p_pre", perm, 0);
        applyStimulus(32'h0);
        waitCycles(1);
        checkOutput("p_rise", perm, 4'b0001);
        checkOutput("p_error", error, 4'b0001);
        checkOutput("p_irq_lag", irq, 0);
        waitCycles(1);
        checkOutput("p_irq", irq, 1);
        checkOutput("p_error_fall", error, 0);
        checkOutput("p_cnt", transCnt, 16'h0020);

        applyStimulus(bitOf(0, 5));
        waitCycles(1);
        applyStimulus(32'h0);
        waitCycles(3);
        checkOutput("p_glitch_cnt", transCnt, 16'h0020);
        checkOutput("p_sticky", perm, 4'b0001);

        clear = 4'b0001;
        waitCycles(1);
        clear = 4'b0000;
        checkOutput("clr_perm", perm, 0);
        checkOutput("clr_cnt", transCnt, 16'h0020);
        checkOutput("clr_irq_lag", irq, 1);
        waitCycles(1);
        checkOutput("clr_irq", irq, 0);
        applyStimulus(bitOf(0, 0));
        waitCycles(1);
        applyStimulus(32'h0);
        waitCycles(2);
        checkOutput("clr_idle", transCnt, 16'h0021);

        thresh = 4'd5;
        model  = 0;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(bitOf(2, 1));
            waitCycles(1);
            checkOutput("sat_irq_early", irq, (model >= 5));
            irqExp = (model >= 5);
            applyStimulus(32'h0);
            waitCycles(2);
            if (model < 15) model++;
            checkOutput("sat_cnt", cntOf(2), model);
            checkOutput("sat_irq", irq, irqExp);
        end
        thresh = 4'd0;
        waitCycles(1);
        checkOutput("thr_off_irq", irq, 0);
        checkOutput("thr_off_cnt", cntOf(2), 15);

        applyStimulus(bitOf(3, 7));
        waitCycles(1);
        applyStimulus(32'h0);
        waitCycles(2);
        checkOutput("prio_pre", cntOf(3), 1);
        applyStimulus(bitOf(3, 7));
        waitCycles(1);
        applyStimulus(32'h0);
        waitCycles(1);
        clear = 4'b1000;
        waitCycles(1);
        clear = 4'b0000;
        checkOutput("prio_cnt", cntOf(3), 0);
        checkOutput("prio_error", error[3], 0);

        applyStimulus(bitOf(3, 7));
        waitCycles(3);
        checkOutput("abort_run", error[3], 1);
        en = 4'b0111;
        waitCycles(1);
        checkOutput("abort_lag", error[3], 1);
        waitCycles(1);
        checkOutput("abort_fall", error[3], 0);
        applyStimulus(32'h0);
        en = 4'hF;
        waitCycles(3);
        checkOutput("abort_cnt", cntOf(3), 0);
        checkOutput("abort_perm", perm[3], 0);

        applyStimulus(bitOf(0, 2));
        waitCycles(6);
        checkOutput("ar_perm_pre", perm, 4'b0001);
        checkOutput("ar_cnt_pre", cntOf(2), 15);
        checkOutput("ar_irq_pre", irq, 1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("ar_error", error, 0);
        checkOutput("ar_perm", perm, 0);
        checkOutput("ar_cnt", transCnt, 0);
        checkOutput("ar_irq", irq, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/com_tr_mc.md
# com_tr_mc

Multi-channel single-event-transient monitor for redundant combinational logic, operating on one clock. Each channel receives two redundantly computed copies of a signal and samples and compares them every cycle. Each mismatch run is classified as transient (short) or permanent (persistent). The block keeps per-channel saturating transient counters and sticky permanent flags, and raises one interrupt toward the safety unit.

## Interface
Parameters:
- N_CH, 4, number of independent monitored channels (≥1)
- IN_WIDTH, 8, bits per copy per channel (≥1)
- CNT_W, 8, width of each transient counter (≥2)
- PERM_CYC, 4, consecutive mismatch cycles that make a run permanent (≥2)

Ports:
- clk_i  in  1  system clock, all logic on posedge
- rstn_i  in  1  reset; reset is asynchronous and active-low
- en_i  in  N_CH  per-channel monitor enable
- sig_a_i  in  N_CH*IN_WIDTH  copy A; channel c occupies bits [c*IN_WIDTH +: IN_WIDTH]
- sig_b_i  in  N_CH*IN_WIDTH  copy B, same packing as sig_a_i
- clear_i  in  N_CH  synchronous per-channel clear of counter, run state and permanent flag
- thresh_i  in  CNT_W  transient-count interrupt threshold; 0 disables the threshold term
- error_o  out  N_CH  registered per-channel mismatch flag
- trans_cnt_o  out  N_CH*CNT_W  per-channel transient counters, same packing scheme
- perm_o  out  N_CH  sticky per-channel permanent-fault flag
- irq_o  out  1  registered interrupt

## Operation
- Stage 1: each posedge registers sig_a_i and sig_b_i into a_q and b_q. The enable is registered alongside as en_q.
- Stage 2: mism = en_q[c] & |(a_q ^ b_q) for channel c. error_o[c] <= mism.
- Each channel has a run-length counter of width $clog2(PERM_CYC+1) and a state machine with states IDLE, RUN and PERM:
  - IDLE: when mism = 1, go to RUN with run = 1.
  - RUN, mism = 1: run increments. If the incremented run equals PERM_CYC, go to PERM and set perm_o.
  - RUN, mism = 0: the run ended while shorter than PERM_CYC. It counts as a transient: increment trans_cnt, then go to IDLE with run = 0.
  - RUN, en_q = 0: abort the run. Go to IDLE and do not count it.
  - PERM: absorbing. perm_o stays 1 and no further transients are counted. Only clear_i or reset leaves PERM.
- trans_cnt saturates at 2^CNT_W−1 and never wraps.
- clear_i[c] takes priority over any same-cycle increment or state transition. The next state is IDLE with run = 0, cnt = 0 and perm = 0.
- irq_o <= OR over channels of (perm[c] | (thresh_i != 0 && trans_cnt[c] >= thresh_i)). The unsigned compare uses the current counter value.
- Channels are fully independent; no event on one channel affects another.

## Timing
- All outputs are 0 during and immediately after reset. Assertion of rstn_i clears every flop asynchronously, including mid-run and in PERM.
- Input presented before edge t is captured at edge t. error_o reflects it after edge t+1, giving a latency of 2 edges.
- A transient run ending at error_o falling edge k increments trans_cnt_o at the same edge k, when the state machine sees mism = 0.
- perm_o rises on the edge where error_o has been high for PERM_CYC consecutive cycles, i.e. run reaches PERM_CYC.
- irq_o lags perm_o or trans_cnt_o by one edge.
- clear_i takes effect at the next edge. If it is held, the channel stays cleared, but error_o still tracks mism.
- A run of exactly PERM_CYC−1 cycles is transient; a run of exactly PERM_CYC cycles is permanent.

## Structure
- Package com_tr_pkg holds the state enum typedef (IDLE, RUN, PERM) and a helper function returning $clog2(PERM_CYC+1).
- Sub-module com_tr_ch implements one channel: compare, state machine, run counter and saturating counter. The top instantiates it N_CH times in a generate loop, samples the inputs, and builds the irq_o reduction.

## Test plan
- Reset and idle: hold sig_a_i = sig_b_i with random values, all channels enabled, for 100 cycles → error_o, perm_o, trans_cnt_o and irq_o stay 0.
- Transient: flip bit 3 of channel 1 copy B for 1 cycle, then for 3 cycles, with PERM_CYC = 4 → channel 1 counter goes 1 then 2 and perm_o[1] = 0. error_o[1] pulses 2 edges after each stimulus and the other channels are unaffected.
- Permanent: hold a mismatch on channel 0 for 4 cycles → perm_o[0] = 1 on the 4th error_o-high edge and irq_o = 1 one edge later. Further glitches leave trans_cnt_o[0] unchanged. A clear_i[0] pulse returns the channel to 0/0/IDLE.
- Saturation and threshold: with CNT_W = 4 and thresh_i = 5, inject 20 single-cycle glitches → irq_o rises one edge after the count reaches 5 and the counter stops at 15. Setting thresh_i = 0 drops irq_o.
- Priority and enable: assert clear_i in the same cycle a transient run ends → the counter reads 0. Deassert en_i mid-run → the run is aborted uncounted and error_o falls 2 edges later.
- Async reset with a channel in PERM and counters nonzero → all outputs 0 immediately, without waiting for a clock edge.
